// File: rtl/dcache_direct_mapped_if.sv
// dcache_direct_mapped_if: processor request port and block memory port of the data cache
interface dcache_direct_mapped_if #(parameter int ADDR_W = 7);
   logic              proc_read;
   logic              proc_write;
   logic [ADDR_W-1:0] proc_addr;
   logic [31:0]       proc_wdata;
   logic [31:0]       proc_rdata;
   logic              proc_stall;
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-3:0] mem_addr;
   logic [127:0]      mem_wdata;
   logic [127:0]      mem_rdata;
   logic              mem_ready;
   modport master (
      output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
      input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
   );
   modport slave (
      input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
      output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
   );
endinterface

// File: rtl/dcache_direct_mapped.sv
// dcache_direct_mapped: direct-mapped write-back write-allocate data cache with 4-word blocks
module dcache_direct_mapped #(
   parameter int ADDR_W = 7,
   parameter int LINES  = 8
) (
   input logic                  clk,
   input logic                  rst,
   dcache_direct_mapped_if.slave bus
);
   localparam int INDEX_W = $clog2(LINES);
   localparam int TAG_W   = ADDR_W - 2 - INDEX_W;
   typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOCATE} state_t;
   state_t             state, state_nx;
   logic [LINES-1:0]   valid, dirty;
   logic [TAG_W-1:0]   tags [LINES];
   logic [127:0]       data [LINES];
   logic [TAG_W-1:0]   req_tag;
   logic [INDEX_W-1:0] idx;
   logic [1:0]         off;
   logic               req, hit, fill, store;
   assign {req_tag, idx, off} = bus.proc_addr;
   assign req   = bus.proc_read | bus.proc_write;
   assign hit   = valid[idx] && tags[idx] == req_tag;
   assign fill  = state == ALLOCATE && bus.mem_ready;
   assign store = state == COMPARE && hit && bus.proc_write;
   // state register; reset abandons any in-flight transfer
   always_ff @(posedge clk) begin
      if (rst) state <= COMPARE;
      else     state <= state_nx;
   end
   // next state: a miss evicts a dirty victim first, then refills
   always_comb begin
      state_nx = state;
      if (state == COMPARE)
         state_nx = (req && !hit) ? ((valid[idx] && dirty[idx]) ? WRITEBACK : ALLOCATE) : COMPARE;
      else if (state == WRITEBACK)
         state_nx = bus.mem_ready ? ALLOCATE : WRITEBACK;
      else
         state_nx = bus.mem_ready ? COMPARE : ALLOCATE;
   end
   // outputs: memory strobes from state only; processor sees data only on a hit in COMPARE
   always_comb begin
      bus.mem_read   = state == ALLOCATE;
      bus.mem_write  = state == WRITEBACK;
      bus.mem_addr   = (state == WRITEBACK) ? {tags[idx], idx} : {req_tag, idx};
      bus.mem_wdata  = data[idx];
      bus.proc_stall = (state != COMPARE) || (req && !hit);
      bus.proc_rdata = (state == COMPARE && hit && bus.proc_read) ? data[idx][{off, 5'd0} +: 32] : 32'd0;
   end
   // line data and tags: block refill, or word merge on a store hit
   always_ff @(posedge clk) begin
      if (fill) begin
         data[idx] <= bus.mem_rdata;
         tags[idx] <= req_tag;
      end else if (store) begin
         data[idx][{off, 5'd0} +: 32] <= bus.proc_wdata;
      end
   end
   // line status: refill leaves the line clean, a store marks it dirty
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= '0;
         dirty <= '0;
      end else if (fill) begin
         valid[idx] <= 1'b1;
         dirty[idx] <= 1'b0;
      end else if (store) begin
         dirty[idx] <= 1'b1;
      end
   end
endmodule

// File: tb/tb_dcache_direct_mapped.sv
// tb_dcache_direct_mapped: random and directed accesses against a line-status plus flat-memory model
module tb_dcache_direct_mapped;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [31:0] bmem   [128];
   logic [31:0] shadow [128];
   logic        mv [8];
   logic        md [8];
   logic [1:0]  mt [8];
   dcache_direct_mapped_if #(.ADDR_W(7)) bus ();
   dcache_direct_mapped #(.ADDR_W(7), .LINES(8)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         mv[k] = 1'b0;
         md[k] = 1'b0;
      end
      for (int k = 0; k < 128; k++) shadow[k] = bmem[k];
   endtask
   function automatic logic [127:0] block_of(input logic [31:0] w [128], input logic [4:0] blk);
      int b;
      b = int'(blk) * 4;
      return {w[b+3], w[b+2], w[b+1], w[b]};
   endfunction
   task automatic transfer(input logic wb, input logic [4:0] blk, input int dly);
      logic [127:0] wexp;
      wexp = block_of(shadow, blk);
      bus.mem_rdata = wb ? {$urandom, $urandom, $urandom, $urandom} : block_of(bmem, blk);
      for (int c = 0; c <= dly; c++) begin
         bus.mem_ready = (c == dly);
         #2;
         check("mem_write", bus.mem_write, wb);
         check("mem_read", bus.mem_read, !wb);
         check("mem_addr", bus.mem_addr, blk);
         check("xfer_stall", bus.proc_stall, 1);
         if (wb) check("wb_data", bus.mem_wdata, wexp);
         tick();
      end
      bus.mem_ready = 1'b0;
      if (wb) for (int k = 0; k < 4; k++) bmem[int'(blk)*4+k] = shadow[int'(blk)*4+k];
   endtask
   task automatic access(input logic rd, input logic wr, input logic [6:0] a, input logic [31:0] wd, input int dly);
      logic [2:0] i;
      logic [1:0] t;
      logic       hit_e;
      t = a[6:5];
      i = a[4:2];
      hit_e = mv[i] && mt[i] == t;
      bus.proc_read  = rd;
      bus.proc_write = wr;
      bus.proc_addr  = a;
      bus.proc_wdata = wd;
      #2;
      check("first_stall", bus.proc_stall, !hit_e);
      if (!hit_e) begin
         check("miss_rdata", bus.proc_rdata, 0);
         check("miss_memrd", bus.mem_read, 0);
         tick();
         if (mv[i] && md[i]) transfer(1'b1, {mt[i], i}, dly);
         transfer(1'b0, {t, i}, dly);
         mv[i] = 1'b1;
         mt[i] = t;
         md[i] = 1'b0;
         #2;
         check("hit_stall", bus.proc_stall, 0);
      end
      check("hit_memrd", bus.mem_read, 0);
      check("hit_memwr", bus.mem_write, 0);
      if (rd && !wr) check("rdata", bus.proc_rdata, shadow[a]);
      if (wr) begin
         shadow[a] = wd;
         md[i] = 1'b1;
      end
      tick();
      bus.proc_read  = 1'b0;
      bus.proc_write = 1'b0;
   endtask
   initial begin
      bus.proc_read  = 1'b0;
      bus.proc_write = 1'b0;
      bus.proc_addr  = '0;
      bus.proc_wdata = '0;
      bus.mem_rdata  = '0;
      bus.mem_ready  = 1'b0;
      for (int k = 0; k < 128; k++) bmem[k] = $urandom;
      bmem[4] = 32'hAAAA_0000;
      bmem[5] = 32'hBBBB_1111;
      bmem[6] = 32'hCCCC_2222;
      bmem[7] = 32'hDDDD_3333;
      do_reset();
      #2;
      check("rst_stall", bus.proc_stall, 0);
      check("rst_memrd", bus.mem_read, 0);
      check("rst_memwr", bus.mem_write, 0);
      check("rst_rdata", bus.proc_rdata, 0);
      tick();
      access(1'b1, 1'b0, 7'h05, 32'd0, 2);
      access(1'b1, 1'b0, 7'h04, 32'd0, 0);
      access(1'b0, 1'b1, 7'h06, 32'hDEAD_BEEF, 0);
      access(1'b1, 1'b0, 7'h06, 32'd0, 0);
      check("dirty_word", shadow[6], 32'hDEAD_BEEF);
      access(1'b1, 1'b0, 7'h26, 32'd0, 1);
      check("wb_word2", bmem[6], 32'hDEAD_BEEF);
      bus.proc_read = 1'b1;
      bus.proc_addr = 7'h05;
      #2;
      check("r5_stall", bus.proc_stall, 1);
      tick();
      #2;
      check("alloc_memrd", bus.mem_read, 1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #2;
      check("post_rst_memrd", bus.mem_read, 0);
      check("post_rst_memwr", bus.mem_write, 0);
      bus.proc_read = 1'b0;
      for (int k = 0; k < 8; k++) begin
         mv[k] = 1'b0;
         md[k] = 1'b0;
      end
      for (int k = 0; k < 128; k++) shadow[k] = bmem[k];
      tick();
      access(1'b1, 1'b0, 7'h05, 32'd0, 1);
      bus.mem_ready = 1'b1;
      #2;
      check("idle_stall", bus.proc_stall, 0);
      check("idle_memrd", bus.mem_read, 0);
      check("idle_memwr", bus.mem_write, 0);
      check("idle_rdata", bus.proc_rdata, 0);
      tick();
      bus.mem_ready = 1'b0;
      access(1'b1, 1'b0, 7'h05, 32'd0, 0);
      for (int n = 0; n < 300; n++) begin
         int op;
         op = int'($urandom_range(0, 9));
         if (op == 0) begin
            bus.mem_ready = 1'($urandom_range(0, 1));
            #2;
            check("rnd_idle_stall", bus.proc_stall, 0);
            check("rnd_idle_mem", {bus.mem_read, bus.mem_write}, 0);
            tick();
            bus.mem_ready = 1'b0;
         end else begin
            access(op < 5, op >= 5, 7'($urandom_range(0, 127)), $urandom, int'($urandom_range(0, 3)));
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
